// File: rtl/kl8e_tx_ctrl.sv
// KL8E console transmitter IOT controller: decodes 603x/604x IOTs and sequences
// flag, load and skip actions. Define KL8E_SPI_EN to enable SPI (op 5) skip-on-interrupt.
module kl8e_tx_ctrl #(
    parameter int          LOAD_CYCLES = 2,
    parameter logic [5:0]  DEV_CODE    = 6'o04
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        iot_strobe,
    input  logic [0:11] instr,
    input  logic [0:11] ac,
    input  logic        tx_flag,
    input  logic        kbd_flag,
    output logic        tx_load,
    output logic        tx_set_flag,
    output logic        tx_clear_flag,
    output logic [0:11] tx_char,
    output logic        iot_done,
    output logic        skip,
    output logic        int_req
);

`ifdef KL8E_SPI_EN
    localparam bit SPI_EN = 1'b1;
`else
    localparam bit SPI_EN = 1'b0;
`endif

    localparam logic [5:0] KIE_DEV   = 6'o03;
    localparam logic [3:0] LOAD_INIT = 4'(LOAD_CYCLES);

    localparam logic [2:0] OP_TFL = 3'd0;
    localparam logic [2:0] OP_TSF = 3'd1;
    localparam logic [2:0] OP_TCF = 3'd2;
    localparam logic [2:0] OP_TPC = 3'd4;
    localparam logic [2:0] OP_SPI = 3'd5;
    localparam logic [2:0] OP_TLS = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_CLR,
        S_LOAD,
        S_ACK,
        S_HOLD
    } state_t;

    state_t      state;
    logic [2:0]  op_l;
    logic [0:11] ac_l;
    logic        tx_flag_l;
    logic        kbd_flag_l;
    logic        kie_l;
    logic [3:0]  cnt;
    logic        ie;

    logic [2:0]  op_in;
    logic [5:0]  dev_in;
    logic        hit_tx;
    logic        hit_kie;
    logic        accept;
    logic        skip_now;

    // Bit 0 is the MSB (PDP-8 numbering): group in [0:2], device in [3:8], op in [9:11].
    always_comb begin
        op_in   = instr[9:11];
        dev_in  = instr[3:8];
        hit_tx  = (dev_in == DEV_CODE);
        hit_kie = (dev_in == KIE_DEV) && (op_in == OP_SPI);
        accept  = iot_strobe && (instr[0:2] == 3'o6) && (hit_tx || hit_kie);
    end

    // Skip uses only values captured in IDLE, so late tx_flag changes cannot disturb it.
    always_comb begin
        skip_now = 1'b0;
        if (!kie_l) begin
            if (op_l == OP_TSF)
                skip_now = tx_flag_l;
            else if (op_l == OP_SPI)
                skip_now = SPI_EN && ie && (tx_flag_l || kbd_flag_l);
        end
    end

    // NOTE: every register here is plain control state (no memory arrays), so all of
    // it takes the async reset; sequential updates use non-blocking assignments only.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            op_l          <= 3'd0;
            ac_l          <= 12'o0000;
            tx_flag_l     <= 1'b0;
            kbd_flag_l    <= 1'b0;
            kie_l         <= 1'b0;
            cnt           <= 4'd0;
            ie            <= 1'b1;
            tx_load       <= 1'b0;
            tx_set_flag   <= 1'b0;
            tx_clear_flag <= 1'b0;
            tx_char       <= 12'o0000;
            iot_done      <= 1'b0;
            skip          <= 1'b0;
            int_req       <= 1'b0;
        end else begin
            tx_load       <= 1'b0;
            tx_set_flag   <= 1'b0;
            tx_clear_flag <= 1'b0;
            iot_done      <= 1'b0;
            skip          <= 1'b0;
            int_req       <= ie && tx_flag;

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_l       <= op_in;
                        ac_l       <= ac;
                        tx_flag_l  <= tx_flag;
                        kbd_flag_l <= kbd_flag;
                        kie_l      <= hit_kie && !hit_tx;
                        state      <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    state <= S_ACK;
                    if (kie_l) begin
                        ie <= ac_l[11];
                    end else begin
                        case (op_l)
                            OP_TFL:         tx_set_flag <= 1'b1;
                            OP_TCF, OP_TLS: state <= S_CLR;
                            OP_TPC: begin
                                cnt   <= LOAD_INIT;
                                state <= S_LOAD;
                            end
                            default: ;
                        endcase
                    end
                end

                S_CLR: begin
                    tx_clear_flag <= 1'b1;
                    if (op_l == OP_TLS) begin
                        cnt   <= LOAD_INIT;
                        state <= S_LOAD;
                    end else begin
                        state <= S_ACK;
                    end
                end

                S_LOAD: begin
                    tx_load <= 1'b1;
                    tx_char <= ac_l;
                    cnt     <= cnt - 4'd1;
                    if (cnt <= 4'd1)
                        state <= S_ACK;
                end

                S_ACK: begin
                    iot_done <= 1'b1;
                    skip     <= skip_now;
                    state    <= S_HOLD;
                end

                S_HOLD: begin
                    if (!iot_strobe)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kl8e_tx_ctrl.sv
// Directed-vector bench for kl8e_tx_ctrl (default LOAD_CYCLES=2, DEV_CODE=6'o04).
// Expected SPI skip follows KL8E_SPI_EN when that macro is defined for the build.
module tb_kl8e_tx_ctrl;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        iot_strobe;
    logic [0:11] instr;
    logic [0:11] ac;
    logic        tx_flag;
    logic        kbd_flag;
    logic        tx_load;
    logic        tx_set_flag;
    logic        tx_clear_flag;
    logic [0:11] tx_char;
    logic        iot_done;
    logic        skip;
    logic        int_req;

    int checks = 0;
    int errors = 0;

    int          done_at, n_done, n_load, n_clr, n_set, first_clr, first_load;
    logic        skip_seen;
    logic [0:11] char_seen;
    logic [31:0] int_hist;
    int          done_in_reset;

`ifdef KL8E_SPI_EN
    localparam logic SPI_EXP = 1'b1;
`else
    localparam logic SPI_EXP = 1'b0;
`endif

    kl8e_tx_ctrl dut (
        .clk100        (clk100),
        .reset         (reset),
        .iot_strobe    (iot_strobe),
        .instr         (instr),
        .ac            (ac),
        .tx_flag       (tx_flag),
        .kbd_flag      (kbd_flag),
        .tx_load       (tx_load),
        .tx_set_flag   (tx_set_flag),
        .tx_clear_flag (tx_clear_flag),
        .tx_char       (tx_char),
        .iot_done      (iot_done),
        .skip          (skip),
        .int_req       (int_req)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise the strobe before edge n, then observe 32 cycles; cycle k = just after edge n+k.
    task automatic run_iot(input logic [0:11] i_w, input logic [0:11] a_w,
                           input logic txf, input logic kbf, input logic txf_after,
                           input int hold);
        done_at = -1; first_clr = -1; first_load = -1;
        n_done = 0; n_load = 0; n_clr = 0; n_set = 0;
        skip_seen = 1'b0; char_seen = 12'o0000; int_hist = '0;
        @(negedge clk100);
        instr = i_w; ac = a_w; tx_flag = txf; kbd_flag = kbf; iot_strobe = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk100);
            #1;
            if (k == 0) tx_flag = txf_after;
            if (iot_done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at   = k;
                    skip_seen = skip;
                end
            end
            if (tx_load) begin
                n_load++;
                char_seen = tx_char;
                if (first_load < 0) first_load = k;
            end
            if (tx_clear_flag) begin
                n_clr++;
                if (first_clr < 0) first_clr = k;
            end
            if (tx_set_flag) n_set++;
            int_hist[k] = int_req;
            if (k + 1 >= hold) iot_strobe = 1'b0;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; iot_strobe = 1'b0; instr = 12'o0000; ac = 12'o0000;
        tx_flag = 1'b0; kbd_flag = 1'b0;
        repeat (3) @(negedge clk100);
        check("reset_outputs", {tx_load, tx_set_flag, tx_clear_flag, iot_done, skip, int_req}, 6'b0);
        check("reset_tx_char", tx_char, 12'o0000);
        reset = 1'b1;
        repeat (2) @(negedge clk100);

        run_iot(12'o6040, 12'o0000, 1'b0, 1'b0, 1'b0, 6);
        check("tfl_done_at", done_at, 2);
        check("tfl_set_flag", n_set, 1);
        check("tfl_done_count", n_done, 1);

        run_iot(12'o6041, 12'o0000, 1'b1, 1'b0, 1'b1, 6);
        check("tsf1_done_at", done_at, 2);
        check("tsf1_skip", skip_seen, 1);

        run_iot(12'o6041, 12'o0000, 1'b0, 1'b0, 1'b0, 6);
        check("tsf0_skip", skip_seen, 0);

        run_iot(12'o6042, 12'o0000, 1'b0, 1'b0, 1'b0, 6);
        check("tcf_done_at", done_at, 3);
        check("tcf_clr", n_clr, 1);
        check("tcf_no_load", n_load, 0);

        run_iot(12'o6046, 12'o0110, 1'b0, 1'b0, 1'b0, 6);
        check("tls_clr_at", first_clr, 2);
        check("tls_clr_count", n_clr, 1);
        check("tls_load_at", first_load, 3);
        check("tls_load_count", n_load, 2);
        check("tls_char", char_seen, 12'o0110);
        check("tls_done_at", done_at, 5);

        run_iot(12'o6044, 12'o0105, 1'b0, 1'b0, 1'b0, 20);
        check("tpc_hold_load", n_load, 2);
        check("tpc_hold_done", n_done, 1);
        check("tpc_hold_done_at", done_at, 4);
        check("tpc_hold_char", char_seen, 12'o0105);
        check("tx_char_held", tx_char, 12'o0105);

        run_iot(12'o6034, 12'o0777, 1'b1, 1'b0, 1'b1, 6);
        check("other_dev_done", n_done, 0);
        check("other_dev_load", n_load, 0);

        run_iot(12'o7044, 12'o0777, 1'b1, 1'b0, 1'b1, 6);
        check("non_iot_done", n_done, 0);

        check("int_req_default_ie", int_req, 1);
        run_iot(12'o6035, 12'o0000, 1'b1, 1'b0, 1'b1, 6);
        check("kie0_done_at", done_at, 2);
        check("kie0_int_req", int_hist[2], 0);

        run_iot(12'o6035, 12'o0001, 1'b1, 1'b0, 1'b1, 6);
        check("kie1_int_req_c1", int_hist[1], 0);
        check("kie1_int_req_c2", int_hist[2], 1);

        run_iot(12'o6045, 12'o0000, 1'b0, 1'b1, 1'b0, 6);
        check("spi_done_at", done_at, 2);
        check("spi_skip", skip_seen, SPI_EXP);

        run_iot(12'o6041, 12'o0000, 1'b1, 1'b0, 1'b0, 6);
        check("tsf_late_flag_skip", skip_seen, 1);

        run_iot(12'o6044, 12'o0321, 1'b0, 1'b0, 1'b0, 1);
        check("early_drop_done", n_done, 1);
        check("early_drop_load", n_load, 2);

        // Reset in the first LOAD cycle of a TPC.
        @(negedge clk100);
        instr = 12'o6044; ac = 12'o0123; iot_strobe = 1'b1;
        repeat (3) @(posedge clk100);
        #1;
        check("pre_reset_load", tx_load, 1);
        reset = 1'b0;
        #1;
        check("reset_load_cleared", tx_load, 0);
        check("reset_char_cleared", tx_char, 12'o0000);
        iot_strobe = 1'b0;
        done_in_reset = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk100);
            if (k == 3) reset = 1'b1;
            if (iot_done) done_in_reset++;
        end
        check("reset_no_done", done_in_reset, 0);

        run_iot(12'o6044, 12'o0777, 1'b0, 1'b0, 1'b0, 6);
        check("post_reset_done_at", done_at, 4);
        check("post_reset_load", n_load, 2);
        check("post_reset_char", char_seen, 12'o0777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
